// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store initiator.
//   lsu_state_e : FSM states (IDLE, ACCESS, WRITE, RESP)
//   F3_*        : RV32I load/store funct3 encodings
//   is_err()    : request legality (alignment, range, funct3)
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // addr_w is the implemented byte-address width; any set bit above it is
   // out of range.
   function automatic logic is_err(input logic        we,
                                   input logic [2:0]  funct3,
                                   input logic [31:0] addr,
                                   input int unsigned addr_w);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = addr[0];
         F3_W:    bad = (addr[1:0] != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we | addr[0];
         default: bad = 1'b1;
      endcase
      if ((addr >> addr_w) != 32'd0) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_master_byte_lane.sv
// lsu_byte_lane: combinational lane extraction and sub-word merge.
//   i_word        : memory word (mem_rd)
//   i_lane        : byte address low bits (addr[1:0])
//   i_funct3      : access size / signedness
//   i_wdata       : right-aligned store data
//   o_load_data   : selected lane, sign- or zero-extended (0 for illegal funct3)
//   o_merge_word  : i_word with the byte/half lane replaced by i_wdata
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_mask;
   logic [31:0] w_ins;

   always_comb begin
      w_byte = 8'(i_word >> {i_lane, 3'b000});
      // half lane is addr[1]; addr[0] is guaranteed 0 for legal halves
      w_half = 16'(i_word >> {i_lane[1], 4'b0000});

      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'd0, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'd0, w_half};
         F3_W:    o_load_data = i_word;
         default: o_load_data = 32'd0;
      endcase

      case (i_funct3)
         F3_B: begin
            w_mask = 32'h0000_00FF << {i_lane, 3'b000};
            w_ins  = {24'd0, i_wdata[7:0]} << {i_lane, 3'b000};
         end
         F3_H: begin
            w_mask = 32'h0000_FFFF << {i_lane[1], 4'b0000};
            w_ins  = {16'd0, i_wdata[15:0]} << {i_lane[1], 4'b0000};
         end
         default: begin
            w_mask = 32'hFFFF_FFFF;
            w_ins  = i_wdata;
         end
      endcase
      o_merge_word = (i_word & ~w_mask) | w_ins;
   end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator toward a word-addressed memory
// with combinational read and synchronous write. Sub-word stores are done as
// read-modify-write; illegal requests respond with an error and never touch
// memory.
// Optional feature macro: LSU_PERF_CNT_EN (adds o_perf_loads/stores/errs).
// Ports:
//   i_clk, i_reset           : clock, async active-high reset
//   i_req_*/o_req_ready      : request; accepted when i_req_valid & o_req_ready
//   o_resp_*                 : one-cycle response pulse, no backpressure
//   o_mem_we/a/wd, i_mem_rd  : memory interface
//   o_state                  : current FSM state (debug)
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both high; o_req_ready is high only in IDLE. o_resp_valid
// is high for exactly one cycle and must be consumed in that cycle.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_funct3,
   input  logic [31:0]       i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_resp_valid,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_a,
   output logic [DATA_W-1:0] o_mem_wd,
   input  logic [DATA_W-1:0] i_mem_rd,
`ifdef LSU_PERF_CNT_EN
   output logic [31:0]       o_perf_loads,
   output logic [31:0]       o_perf_stores,
   output logic [31:0]       o_perf_errs,
`else
   // counter ports exist only when the feature is enabled
`endif
   output lsu_state_e        o_state
);

   lsu_state_e  r_state;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_wdata;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_word;

   assign o_state = r_state;

   lsu_byte_lane u_lane (
      .i_word       (i_mem_rd),
      .i_lane       (r_addr_lo),
      .i_funct3     (r_f3),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_merge_word (w_merge_word)
   );

   // Memory outputs are registered, so they are loaded on the edge that
   // enters the state in which they must be valid: mem_a (and SW's write)
   // on the accept edge, the merged word on the ACCESS->WRITE edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_f3         <= 3'd0;
         r_addr_lo    <= 2'd0;
         r_wdata      <= 32'd0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= 32'd0;
         o_resp_err   <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_a      <= '0;
         o_mem_wd     <= 32'd0;
`ifdef LSU_PERF_CNT_EN
         o_perf_loads  <= 32'd0;
         o_perf_stores <= 32'd0;
         o_perf_errs   <= 32'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_we        <= i_req_we;
                  r_f3        <= i_req_funct3;
                  r_addr_lo   <= i_req_addr[1:0];
                  r_wdata     <= i_req_wdata;
                  o_req_ready <= 1'b0;
                  if (is_err(i_req_we, i_req_funct3, i_req_addr, ADDR_W)) begin
                     o_resp_valid <= 1'b1;
                     o_resp_err   <= 1'b1;
                     o_resp_rdata <= 32'd0;
                     r_state      <= RESP;
                  end else begin
                     o_mem_a <= {i_req_addr[ADDR_W-1:2], 2'b00};
                     if (i_req_we && (i_req_funct3 == F3_W)) begin
                        o_mem_we <= 1'b1;
                        o_mem_wd <= i_req_wdata;
                     end
                     r_state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!r_we) begin
                  o_resp_rdata <= w_load_data;
                  o_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else if (r_f3 == F3_W) begin
                  o_mem_we     <= 1'b0;
                  o_resp_rdata <= 32'd0;
                  o_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else begin
                  o_mem_wd <= w_merge_word;
                  o_mem_we <= 1'b1;
                  r_state  <= WRITE;
               end
            end
            WRITE: begin
               o_mem_we     <= 1'b0;
               o_resp_rdata <= 32'd0;
               o_resp_valid <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               o_resp_valid <= 1'b0;
               o_resp_err   <= 1'b0;
               o_resp_rdata <= 32'd0;
               o_req_ready  <= 1'b1;
               r_state      <= IDLE;
`ifdef LSU_PERF_CNT_EN
               if (o_resp_err)  o_perf_errs   <= o_perf_errs + 32'd1;
               else if (r_we)   o_perf_stores <= o_perf_stores + 32'd1;
               else             o_perf_loads  <= o_perf_loads + 32'd1;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
